drain_counter: RTL and testbench

DRAIN_COUNTER -- requirements
Module: drain_counter

---
 rtl/drain_counter_pkg.sv | 11 +
 rtl/drain_counter.sv | 92 +++++++++
 tb/tb_drain_counter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/drain_counter_pkg.sv
// Shared widths, reset bound and FSM state encoding for the drain counter.
package drain_counter_pkg;
  localparam int W_DEF     = 11;
  localparam int M_RST_DEF = 300;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/drain_counter.sv
// Bounded drain run: j counts load_m down to 0 while a moves by selector,
// clamped to [0, m]. The run lasts load_m+1 cycles, then parks in DONE.
module drain_counter
  import drain_counter_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int M_RST = M_RST_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] load_m,
  input  logic         selector,
  output logic [W-1:0] a,
  output logic [W-1:0] j,
  output logic [W-1:0] m,
  output logic         busy,
  output logic         done,
  output logic         inv_ok
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // RUN   | stepping j down, a up/down by selector
  // DONE  | run finished, values held, start reloads

  state_t       r_state, w_state_nxt;
  logic [W-1:0] r_a, r_j, r_m;
  logic [W-1:0] w_a_nxt, w_j_nxt, w_m_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_j     <= '0;
      r_m     <= W'(M_RST);
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_j     <= w_j_nxt;
      r_m     <= w_m_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_j_nxt     = r_j;
    w_m_nxt     = r_m;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_a_nxt     = load_m;
          w_j_nxt     = load_m;
          w_m_nxt     = load_m;
        end
      end
      ST_RUN: begin
        if (r_j == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_j_nxt = r_j - W'(1);
          // a never crosses 0 or m; together with a starting at j this keeps j <= a
          if (selector) begin
            if (r_a != '0) w_a_nxt = r_a - W'(1);
          end else begin
            if (r_a < r_m) w_a_nxt = r_a + W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign a      = r_a;
  assign j      = r_j;
  assign m      = r_m;
  assign busy   = (r_state == ST_RUN);
  assign done   = (r_state == ST_DONE);
  assign inv_ok = (r_j <= r_a) && (r_a <= r_m);

`ifdef FORMAL
  always_comb begin
    if (!rst) begin
      assert (inv_ok);
      assert (r_a <= r_m);
    end
  end
`endif

endmodule

// File: tb/tb_drain_counter.sv
// Self-checking bench for drain_counter: directed vector table, hand-written
// corner sequences and random traffic against a cycle-count reference model.
module tb_drain_counter;
  import drain_counter_pkg::*;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst, start, selector;
  logic [W-1:0] load_m;
  logic [W-1:0] a, j, m;
  logic         busy, done, inv_ok;

  int n_tests = 0;
  int n_fail  = 0;

  drain_counter #(.W(W), .M_RST(300)) dut (
    .clk(clk), .rst(rst), .start(start), .load_m(load_m), .selector(selector),
    .a(a), .j(j), .m(m), .busy(busy), .done(done), .inv_ok(inv_ok)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 running, 2 done. A run lasts m+1 cycles;
  // after k steps j is m-k and a has moved k times with clamping to [0, m].
  int md_a, md_j, md_m, md_ph, md_t;

  task automatic model_step(input bit r, input bit s, input int ld, input bit sel);
    if (r) begin
      md_a = 0; md_j = 0; md_m = 300; md_ph = 0; md_t = 0;
    end else if (md_ph != 1) begin
      if (s) begin
        md_m = ld; md_a = ld; md_j = ld; md_ph = 1; md_t = 0;
      end
    end else begin
      if (md_t < md_m) begin
        md_j = md_m - (md_t + 1);
        if (sel) md_a = (md_a > 0) ? md_a - 1 : 0;
        else     md_a = (md_a < md_m) ? md_a + 1 : md_m;
      end else begin
        md_ph = 2;
      end
      md_t++;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".a"},      int'(a),      md_a);
    check({tag, ".j"},      int'(j),      md_j);
    check({tag, ".m"},      int'(m),      md_m);
    check({tag, ".busy"},   int'(busy),   int'(md_ph == 1));
    check({tag, ".done"},   int'(done),   int'(md_ph == 2));
    check({tag, ".inv_ok"}, int'(inv_ok), 1);
  endtask

  // Drive at the falling edge, clock once, sample at the next falling edge.
  task automatic tick(input bit r, input bit s, input int ld, input bit sel, input string tag);
    rst = r; start = s; load_m = W'(ld); selector = sel;
    @(posedge clk);
    model_step(r, s, ld, sel);
    @(negedge clk);
    check_model(tag);
  endtask

  typedef struct {
    bit rst; bit start; int load; bit sel;
    int ea; int ej; int em; bit ebusy; bit edone;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit s, input int ld, input bit sel,
                     input int ea, input int ej, input int em, input bit eb, input bit ed);
    vec_t v;
    v.rst = r; v.start = s; v.load = ld; v.sel = sel;
    v.ea = ea; v.ej = ej; v.em = em; v.ebusy = eb; v.edone = ed;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; load_m = '0; selector = 1'b0;
    md_a = 0; md_j = 0; md_m = 300; md_ph = 0; md_t = 0;

    // reset, then load 5 draining with selector=1
    add(1,0,0,0,   0,0,300, 0,0);
    add(0,1,5,1,   5,5,5,   1,0);
    add(0,0,0,1,   4,4,5,   1,0);
    add(0,0,0,1,   3,3,5,   1,0);
    add(0,0,0,1,   2,2,5,   1,0);
    add(0,0,0,1,   1,1,5,   1,0);
    add(0,0,0,1,   0,0,5,   1,0);
    add(0,0,0,1,   0,0,5,   0,1);
    add(0,0,0,1,   0,0,5,   0,1);
    // load 4 refilling: a clamps at m
    add(0,1,4,0,   4,4,4,   1,0);
    add(0,0,0,0,   4,3,4,   1,0);
    add(0,0,0,0,   4,2,4,   1,0);
    add(0,0,0,0,   4,1,4,   1,0);
    add(0,0,0,0,   4,0,4,   1,0);
    add(0,0,0,0,   4,0,4,   0,1);
    // load 0: one RUN cycle then DONE
    add(0,1,0,1,   0,0,0,   1,0);
    add(0,0,0,1,   0,0,0,   0,1);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].rst, vecs[i].start, vecs[i].load, vecs[i].sel, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_a", i),    int'(a),    vecs[i].ea);
      check($sformatf("vec%0d.tbl_j", i),    int'(j),    vecs[i].ej);
      check($sformatf("vec%0d.tbl_m", i),    int'(m),    vecs[i].em);
      check($sformatf("vec%0d.tbl_busy", i), int'(busy), int'(vecs[i].ebusy));
      check($sformatf("vec%0d.tbl_done", i), int'(done), int'(vecs[i].edone));
    end

    // drain run of 3, then a second run with selector held at 1: a ends at 0, never wraps
    tick(0,1,3,1,"drain1_start");
    for (int i = 0; i < 4; i++) tick(0,0,0,1,"drain1");
    tick(0,1,3,1,"drain2_start");
    for (int i = 0; i < 4; i++) tick(0,0,0,1,"drain2");
    check("drain2_a_zero", int'(a), 0);
    check("drain2_done", int'(done), 1);

    // reset mid-run aborts, then a fresh run of 7
    tick(0,1,300,0,"long_start");
    for (int i = 0; i < 10; i++) tick(0,0,0,i[0],"long_run");
    tick(1,1,55,0,"mid_rst");
    check("mid_rst_a", int'(a), 0);
    check("mid_rst_j", int'(j), 0);
    check("mid_rst_m", int'(m), 300);
    check("mid_rst_idle", int'(busy | done), 0);
    tick(0,1,7,1,"after_rst_start");
    for (int i = 0; i < 8; i++) tick(0,0,0,1,"after_rst_run");
    check("after_rst_done", int'(done), 1);
    check("after_rst_m", int'(m), 7);

    // start held with changing load_m during RUN is ignored; start in DONE reloads
    tick(0,1,6,0,"hold_start");
    for (int i = 0; i < 7; i++) tick(0,1,20 + i,i[0],"hold_run");
    check("hold_m_kept", int'(m), 6);
    check("hold_done", int'(done), 1);
    tick(0,1,9,0,"reload");
    check("reload_m", int'(m), 9);
    check("reload_busy", int'(busy), 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit r, s, sel;
      int ld;
      r   = ($urandom_range(0, 79) == 0);
      s   = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 1);
      ld  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2047) % 64 : $urandom_range(0, 12);
      tick(r, s, ld, sel, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
